// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
package imem_pkg;

  // Controller sequence: zero memory, load program, run core.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_t;

  localparam int INS_WIDTH_DEF = 32;
  localparam int INS_DEPTH_DEF = 64;

  // Byte distance between consecutive instruction words.
  localparam int PC_STEP = 4;

endpackage

// File: rtl/imem_pc_gen.sv
// Fetch PC generator: next-PC mux and PC register.
// The PC is confined to the instruction memory window and kept word aligned,
// so the same mask handles sequential wrap and branch target truncation.
module imem_pc_gen
  import imem_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                restart,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                core_stall,
  output logic [PC_WIDTH-1:0] pc
);

  // Keeps bits [ADDR_W+1:2] only: word aligned, inside the memory window.
  localparam logic [PC_WIDTH-1:0] PC_MASK =
    PC_WIDTH'((64'(1) << (ADDR_W + 2)) - 64'(PC_STEP));

  logic [PC_WIDTH-1:0] pc_next;

  // Next-PC priority: leave/restart RUN > branch > stall > sequential.
  always_comb begin
    pc_next = pc;
    if (!run || restart) begin
      pc_next = '0;
    end else if (branch_taken) begin
      pc_next = branch_target & PC_MASK;
    end else if (core_stall) begin
      pc_next = pc;
    end else begin
      pc_next = (pc + PC_WIDTH'(PC_STEP)) & PC_MASK;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory owner: clears the memory, loads a program from a
// valid/ready stream, then releases the core and drives the fetch address.
// Optional macro IMEM_LOAD_CHECKSUM_EN enables the XOR checksum of loaded
// words; without it load_checksum is tied to zero.
//
// state | meaning
// CLEAR | write zero to every word, one per cycle
// LOAD  | accept program words until load_last or memory full
// RUN   | core executes, memory port follows the fetch PC
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter  int INS_WIDTH = INS_WIDTH_DEF,
  parameter  int INS_DEPTH = INS_DEPTH_DEF,
  parameter  int PC_WIDTH  = 32,
  localparam int ADDR_W    = $clog2(INS_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [INS_WIDTH-1:0] load_data,
  input  logic                 load_last,
  input  logic                 core_stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 restart,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic                 imem_we,
  output logic [INS_WIDTH-1:0] imem_wdata,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 core_run,
  output logic [ADDR_W:0]      load_count,
  output logic [INS_WIDTH-1:0] load_checksum
);

  imem_state_t       state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic              last_slot;
  logic              ld_fire;
  logic              ld_done;

  assign last_slot = (ptr == ADDR_W'(INS_DEPTH - 1));
  assign ld_fire   = (state == LOAD) && load_valid;
  assign ld_done   = ld_fire && (load_last || last_slot);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (last_slot) state_next = LOAD;
      LOAD:    if (ld_done)   state_next = RUN;
      RUN:     if (restart)   state_next = CLEAR;
      default:                state_next = CLEAR;
    endcase
  end

  // Memory port and handshake outputs; forced to idle while reset is held.
  always_comb begin
    load_ready = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    core_run   = 1'b0;
    if (!reset) begin
      case (state)
        CLEAR: begin
          imem_we   = 1'b1;
          imem_addr = ptr;
        end
        LOAD: begin
          load_ready = 1'b1;
          imem_we    = load_valid;
          imem_addr  = ptr;
          imem_wdata = load_data;
        end
        RUN: begin
          core_run  = 1'b1;
          imem_addr = pc[ADDR_W+1:2];
        end
        default: ;
      endcase
    end
  end

  // Write pointer and word counter; counter is held through RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      load_count <= '0;
    end else if (state == CLEAR) begin
      if (last_slot) begin
        ptr        <= '0;
        load_count <= '0;
      end else begin
        ptr <= ptr + ADDR_W'(1);
      end
    end else if (ld_fire) begin
      load_count <= load_count + (ADDR_W + 1)'(1);
      ptr        <= ld_done ? '0 : ptr + ADDR_W'(1);
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [INS_WIDTH-1:0] checksum;

  // Running XOR of accepted words, cleared when CLEAR finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if ((state == CLEAR) && last_slot) begin
      checksum <= '0;
    end else if (ld_fire) begin
      checksum <= checksum ^ load_data;
    end
  end

  assign load_checksum = checksum;
`else
  assign load_checksum = '0;
`endif

  imem_pc_gen #(
    .PC_WIDTH (PC_WIDTH),
    .ADDR_W   (ADDR_W)
  ) u_pc_gen (
    .clk           (clk),
    .reset         (reset),
    .run           (state == RUN),
    .restart       (restart),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .core_stall    (core_stall),
    .pc            (pc)
  );

endmodule
